packet_header_encoder: RTL and testbench
========================================

Name: packet_header_encoder

Overview:
Per-port packet transmitter that builds the 64-bit packet header word (destination port, priority, payload length) from a descriptor. It then streams the header and payload words toward the write arbiter input with sop/eop framing. This is the encoder counterpart of the arbiter's header field decoder: one instance per ingress port, output registered, full valid/ready backpressure on all three interfaces.

Parameters:
arbiter_data_width, 64, width of header/payload words (must be >= 14)
priority_width, 3, priority field width (header bits [6:4])
des_port_width, 4, destination port field width (header bits [3:0])
pack_length_width, 7, payload length field width (header bits [13:7])
pkt_count_width, 16, width of sent-packet counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
desc_valid  input  1  descriptor present
desc_ready  output  1  descriptor accepted when desc_valid && desc_ready
desc_priority  input  priority_width  packet priority
desc_des_port  input  des_port_width  destination port
desc_pack_length  input  pack_length_width  payload word count, 0..127
pay_valid  input  1  payload word present
pay_ready  output  1  payload word accepted when pay_valid && pay_ready
pay_data  input  arbiter_data_width  payload word
out_valid  output  1  out_data valid (drives arbiter ready input)
out_ready  input  1  downstream accepts word when out_valid && out_ready
out_data  output  arbiter_data_width  header or payload word
out_sop  output  1  marks header word
out_eop  output  1  marks last word of packet
busy  output  1  packet in progress (state PAYLOAD or out_valid)
pkt_count  output  pkt_count_width  packets fully sent (eop word accepted)

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, out_data=0, out_sop=0, out_eop=0, word counter=0, latched length=0, pkt_count=0. Reset mid-packet drops the packet silently; no eop is emitted.
- Output register load condition: ld = !out_valid || out_ready. While out_valid && !out_ready, out_data/out_sop/out_eop stay stable.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - desc_ready = ld; pay_ready = 0.
  - On a desc handshake: load out_data = {zeros[63:14], len[13:7], prio[6:4], dport[3:0]}, out_sop=1, out_valid=1, and latch len.
  - If len==0: out_eop=1 (header-only packet), stay in IDLE.
  - Otherwise: out_eop=0, counter=0, go to PAYLOAD.
  - Latency: header word visible the cycle after the desc handshake.
- PAYLOAD:
  - desc_ready = 0; pay_ready = ld.
  - On a pay handshake: out_data=pay_data, out_sop=0, out_valid=1, out_eop=(counter==len-1), counter++.
  - On the last word, go to IDLE.
  - If ld && !pay_valid: out_valid clears to 0 (bubble).
- IDLE with ld && no desc: out_valid goes to 0.
- Back-to-back packets: a new descriptor is accepted in the same cycle the previous eop word is accepted downstream (ld=1). Zero-bubble header follows eop.
- pkt_count increments by 1 on each out_valid && out_ready && out_eop and wraps modulo 2^pkt_count_width.
- Counter compare is done at pack_length_width bits; len=127 produces 127 payload words then eop.
- Field truncation: header fields occupy exactly [3:0], [6:4], [13:7]; unused upper bits are always 0.
- desc_* fields are sampled only at handshake; later changes are ignored.
- pay_data arriving in IDLE is never accepted (pay_ready=0).

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, desc_ready=1 (out_valid=0 ⇒ ld=1), pkt_count=0 immediately.
- Single packet, out_ready=1: desc prio=5, dport=0xA, len=3, pay words 0x11, 0x22, 0x33 -> out_data=0x1DA with sop=1, then 0x11, 0x22, 0x33 with eop on 0x33; pkt_count=1.
- Backpressure: same packet with out_ready=0 for 4 cycles on the second payload word -> out_data=0x22 held stable, pay_ready=0 throughout, no word lost or duplicated.
- Header-only: len=0, prio=7, dport=3 -> single word 0x073 with sop=1 and eop=1; state remains IDLE; pkt_count +1.
- Back-to-back: two descriptors (len=1 each) presented continuously -> header2 appears the cycle after payload1/eop accepted; 4 consecutive valid words, pkt_count=2.
- Reset mid-packet: rst_n low after header of len=5 packet -> outputs cleared, next packet starts with a clean header, pkt_count unchanged by the aborted packet.

Source files
------------

// File: rtl/packet_header_encoder.sv
// packet_header_encoder: builds the header word from a packet descriptor, then
// streams the header and payload words toward the write arbiter with sop/eop
// framing. One registered output stage with valid/ready backpressure on the
// descriptor, payload and output interfaces.
module packet_header_encoder #(
  parameter int arbiter_data_width = 64,
  parameter int priority_width     = 3,
  parameter int des_port_width     = 4,
  parameter int pack_length_width  = 7,
  parameter int pkt_count_width    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic [priority_width-1:0]     desc_priority,
  input  logic [des_port_width-1:0]     desc_des_port,
  input  logic [pack_length_width-1:0]  desc_pack_length,
  input  logic                          pay_valid,
  output logic                          pay_ready,
  input  logic [arbiter_data_width-1:0] pay_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [arbiter_data_width-1:0] out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          busy,
  output logic [pkt_count_width-1:0]    pkt_count
);

  localparam int hdr_width = des_port_width + priority_width + pack_length_width;
  localparam logic [pack_length_width-1:0] len_one = 1;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic                            ld;
  logic                            desc_hs;
  logic                            pay_hs;
  logic                            last_word;
  logic [pack_length_width-1:0]    len_q;
  logic [pack_length_width-1:0]    word_cnt;
  logic [arbiter_data_width-1:0]   header_word;

  // The output register may take a new word when empty or when its word leaves.
  assign ld        = !out_valid || out_ready;
  assign desc_hs   = desc_valid && ld && (state_q == IDLE);
  assign pay_hs    = pay_valid && ld && (state_q == PAYLOAD);
  assign last_word = (word_cnt == (len_q - len_one));
  assign busy      = (state_q == PAYLOAD) || out_valid;

  // Header layout: length above priority above destination port, upper bits zero.
  always_comb begin
    header_word = '0;
    header_word[hdr_width-1:0] = {desc_pack_length, desc_priority, desc_des_port};
  end

  // Next-state and handshake ready decode.
  always_comb begin
    state_d    = state_q;
    desc_ready = 1'b0;
    pay_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        desc_ready = ld;
        if (desc_hs && (desc_pack_length != '0)) begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pay_ready = ld;
        if (pay_hs && last_word) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word register plus the latched length and payload word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      len_q     <= '0;
      word_cnt  <= '0;
    end else if (ld) begin
      if (desc_hs) begin
        out_data  <= header_word;
        out_sop   <= 1'b1;
        out_eop   <= (desc_pack_length == '0);
        out_valid <= 1'b1;
        len_q     <= desc_pack_length;
        word_cnt  <= '0;
      end else if (pay_hs) begin
        out_data  <= pay_data;
        out_sop   <= 1'b0;
        out_eop   <= last_word;
        out_valid <= 1'b1;
        word_cnt  <= word_cnt + len_one;
      end else begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

  // Count packets whose eop word has been accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (out_valid && out_ready && out_eop) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_header_encoder.sv
// Testbench for packet_header_encoder: directed scenarios plus randomized
// traffic, checked against a word-level expected stream built per packet.
module tb_packet_header_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [2:0]  desc_priority;
  logic [3:0]  desc_des_port;
  logic [6:0]  desc_pack_length;
  logic        pay_valid;
  logic        pay_ready;
  logic [63:0] pay_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic [15:0] pkt_count;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  typedef struct {
    int prio;
    int dport;
    int len;
  } desc_t;

  desc_t       descQ[$];
  logic [63:0] payQ[$];
  word_t       expQ[$];
  int          hsLog[$];
  logic [63:0] obsQ[$];

  int          compared   = 0;
  int          mismatched = 0;
  int          expPkts    = 0;
  int          cycle      = 0;
  int          descProb   = 100;
  int          payProb    = 100;
  int          readyProb  = 100;
  bit          holdEn     = 1'b0;
  logic [63:0] holdWord   = '0;
  int          holdCnt    = 0;
  bit          stallPrev  = 1'b0;
  logic [63:0] prevData   = '0;
  logic [2:0]  prevFlags  = '0;

  always #5 clk = ~clk;

  packet_header_encoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_priority    (desc_priority),
    .desc_des_port    (desc_des_port),
    .desc_pack_length (desc_pack_length),
    .pay_valid        (pay_valid),
    .pay_ready        (pay_ready),
    .pay_data         (pay_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_sop          (out_sop),
    .out_eop          (out_eop),
    .busy             (busy),
    .pkt_count        (pkt_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue one packet: descriptor, its payload words, and the words expected out.
  task automatic addPacket(input int p, input int d, input int l, input bit fixedWords);
    desc_t ds;
    word_t w;
    ds.prio  = p;
    ds.dport = d;
    ds.len   = l;
    descQ.push_back(ds);
    w.data = 64'(l) * 64'd128 + 64'(p) * 64'd16 + 64'(d);
    w.sop  = 1'b1;
    w.eop  = (l == 0);
    expQ.push_back(w);
    for (int i = 0; i < l; i++) begin
      w.data = fixedWords ? 64'((i + 1) * 17) : {$urandom, $urandom};
      w.sop  = 1'b0;
      w.eop  = (i == l - 1);
      payQ.push_back(w.data);
      expQ.push_back(w);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then score the handshakes
  // that the coming rising edge will perform.
  task automatic applyStimulus();
    word_t e;
    @(negedge clk);
    if (stallPrev) begin
      checkOutput("hold_data", out_data, prevData);
      checkOutput("hold_flags", 64'({out_sop, out_eop, out_valid}), 64'(prevFlags));
    end
    checkOutput("pkt_count", 64'(pkt_count), 64'(expPkts));

    desc_valid = (descQ.size() > 0) && ($urandom_range(99, 0) < descProb);
    if (desc_valid) begin
      desc_priority    = 3'(descQ[0].prio);
      desc_des_port    = 4'(descQ[0].dport);
      desc_pack_length = 7'(descQ[0].len);
    end else begin
      desc_priority    = 3'($urandom);
      desc_des_port    = 4'($urandom);
      desc_pack_length = 7'($urandom);
    end
    pay_valid = (payQ.size() > 0) && ($urandom_range(99, 0) < payProb);
    pay_data  = pay_valid ? payQ[0] : {$urandom, $urandom};
    if (holdEn && out_valid && (out_data == holdWord) && (holdCnt < 4)) begin
      out_ready = 1'b0;
      holdCnt++;
    end else begin
      out_ready = ($urandom_range(99, 0) < readyProb);
    end
    #1;

    if (out_valid && !out_ready) begin
      checkOutput("stall_ready", 64'({desc_ready, pay_ready}), 64'd0);
    end
    if (desc_valid && desc_ready) void'(descQ.pop_front());
    if (pay_valid && pay_ready) void'(payQ.pop_front());
    if (out_valid && out_ready) begin
      hsLog.push_back(cycle);
      obsQ.push_back(out_data);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", out_data, 64'hDEAD_0000_DEAD_0000);
      end else begin
        e = expQ.pop_front();
        checkOutput("word_data", out_data, e.data);
        checkOutput("word_sop", 64'(out_sop), 64'(e.sop));
        checkOutput("word_eop", 64'(out_eop), 64'(e.eop));
        if (e.eop) expPkts++;
      end
    end
    stallPrev = out_valid && !out_ready;
    prevData  = out_data;
    prevFlags = {out_sop, out_eop, out_valid};
    cycle++;
  endtask

  task automatic runUntilDrained(input int maxCycles);
    int n = 0;
    while ((expQ.size() > 0 || descQ.size() > 0 || payQ.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain", 64'(expQ.size() + descQ.size() + payQ.size()), 64'd0);
  endtask

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic resetMidCycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_desc_ready", 64'(desc_ready), 64'd1);
    checkOutput("rst_pay_ready", 64'(pay_ready), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_sop_eop_busy", 64'({out_sop, out_eop, busy}), 64'd0);
    descQ.delete();
    payQ.delete();
    expQ.delete();
    expPkts    = 0;
    stallPrev  = 1'b0;
    holdEn     = 1'b0;
    desc_valid = 1'b0;
    pay_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    desc_valid       = 1'b0;
    desc_priority    = '0;
    desc_des_port    = '0;
    desc_pack_length = '0;
    pay_valid        = 1'b0;
    pay_data         = '0;
    out_ready        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus();
    resetMidCycle();

    $display("[TB] single packet");
    obsQ.delete();
    addPacket(5, 10, 3, 1'b1);
    runUntilDrained(200);
    checkOutput("single_hdr", obsQ[0], 64'h1DA);
    checkOutput("single_last", obsQ[3], 64'h33);
    applyStimulus();
    checkOutput("single_pkts", 64'(pkt_count), 64'd1);

    $display("[TB] backpressure on second payload word");
    holdEn   = 1'b1;
    holdWord = 64'h22;
    holdCnt  = 0;
    addPacket(5, 10, 3, 1'b1);
    runUntilDrained(200);
    checkOutput("hold_cycles", 64'(holdCnt), 64'd4);
    holdEn = 1'b0;

    $display("[TB] header-only packet");
    obsQ.delete();
    addPacket(7, 3, 0, 1'b0);
    runUntilDrained(50);
    applyStimulus();
    checkOutput("hdr_only_word", obsQ[0], 64'h073);
    checkOutput("hdr_only_busy", 64'({busy, out_valid}), 64'd0);

    $display("[TB] back-to-back packets");
    hsLog.delete();
    addPacket(1, 2, 1, 1'b0);
    addPacket(6, 9, 1, 1'b0);
    runUntilDrained(100);
    checkOutput("b2b_words", 64'(hsLog.size()), 64'd4);
    checkOutput("b2b_span", 64'(hsLog[3] - hsLog[0]), 64'd3);

    $display("[TB] reset mid-packet");
    hsLog.delete();
    addPacket(4, 5, 5, 1'b0);
    n = 0;
    while (hsLog.size() == 0 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("mid_hdr_seen", 64'(hsLog.size()), 64'd1);
    resetMidCycle();
    addPacket(2, 1, 2, 1'b0);
    runUntilDrained(100);
    applyStimulus();
    checkOutput("after_abort_pkts", 64'(pkt_count), 64'd1);

    $display("[TB] randomized traffic");
    descProb  = 70;
    payProb   = 60;
    readyProb = 65;
    for (int i = 0; i < 40; i++) begin
      addPacket(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(12, 0)), 1'b0);
    end
    addPacket(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)), 127, 1'b0);
    for (int i = 0; i < 5; i++) begin
      addPacket(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(3, 0)), 1'b0);
    end
    runUntilDrained(20000);
    applyStimulus();
    checkOutput("final_pkts", 64'(pkt_count), 64'(expPkts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
